wb_grf: RTL

Write-back stage and general register file for the five-stage MIPS pipeline. Consumes the M→W pipeline register outputs (instruction, PC+8, compare flag, ALU result, memory read data), decodes the destination and data source, and commits the result into a 32×32 register file. Serves the two D-stage read ports with internal write-to-read bypass. Publishes the write event for forwarding and trace.

---
 rtl/wb_grf_if.sv | 29 ++
 rtl/wb_grf.sv | 99 +++++++++
 2 files changed

// File: rtl/wb_grf_if.sv
// Bus between the M->W pipeline register / D-stage read ports and the
// write-back + register file block.
interface wb_grf_if;
    logic [31:0] W_instr;
    logic [31:0] W_PC8;
    logic        W_CMP_result;
    logic [31:0] W_ALU_result;
    logic [31:0] W_MEM_read_data;
    logic [4:0]  D_rs_addr;
    logic [4:0]  D_rt_addr;
    logic [31:0] D_rs_data;
    logic [31:0] D_rt_data;
    logic        W_wb_en;
    logic [4:0]  W_wb_addr;
    logic [31:0] W_wb_data;
    logic [31:0] W_wb_pc;

    modport master (
        output W_instr, W_PC8, W_CMP_result, W_ALU_result, W_MEM_read_data,
        output D_rs_addr, D_rt_addr,
        input  D_rs_data, D_rt_data, W_wb_en, W_wb_addr, W_wb_data, W_wb_pc
    );

    modport slave (
        input  W_instr, W_PC8, W_CMP_result, W_ALU_result, W_MEM_read_data,
        input  D_rs_addr, D_rt_addr,
        output D_rs_data, D_rt_data, W_wb_en, W_wb_addr, W_wb_data, W_wb_pc
    );
endinterface

// File: rtl/wb_grf.sv
// MIPS write-back stage: decodes destination/source of the W instruction and
// commits into a 32x32 register file with write-to-read bypass on both ports.
module wb_grf (
    input  logic   clk,
    input  logic   reset,
    wb_grf_if.slave bus
);
    typedef enum logic [1:0] {SRC_ALU, SRC_MEM, SRC_PC8} wb_src_t;

    logic [31:0] regs [32];

    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic        has_dst;
    logic [4:0]  dst;
    wb_src_t     src;
    logic [31:0] src_data;
    logic        wb_en;

    assign opcode = bus.W_instr[31:26];
    assign rt     = bus.W_instr[20:16];
    assign rd     = bus.W_instr[15:11];
    assign funct  = bus.W_instr[5:0];

    always_comb begin
        has_dst = 1'b0;
        dst     = '0;
        src     = SRC_ALU;
        case (opcode)
            6'b000000: begin
                if (funct == 6'b100001 || funct == 6'b100011 || funct == 6'b000000) begin
                    has_dst = 1'b1;
                    dst     = rd;
                end
            end
            6'b001101, 6'b001111: begin
                has_dst = 1'b1;
                dst     = rt;
            end
            6'b100011: begin
                has_dst = 1'b1;
                dst     = rt;
                src     = SRC_MEM;
            end
            6'b000011: begin
                has_dst = 1'b1;
                dst     = 5'd31;
                src     = SRC_PC8;
            end
            6'b000001: begin
                // bgezal links only when the carried compare says taken
                if (rt == 5'b10001 && bus.W_CMP_result) begin
                    has_dst = 1'b1;
                    dst     = 5'd31;
                    src     = SRC_PC8;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        case (src)
            SRC_MEM: src_data = bus.W_MEM_read_data;
            SRC_PC8: src_data = bus.W_PC8;
            default: src_data = bus.W_ALU_result;
        endcase
    end

    assign wb_en         = has_dst && (dst != 5'd0);
    assign bus.W_wb_en   = wb_en;
    assign bus.W_wb_addr = wb_en ? dst : '0;
    assign bus.W_wb_data = wb_en ? src_data : '0;
    assign bus.W_wb_pc   = bus.W_PC8 - 32'd8;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_en) begin
            regs[dst] <= src_data;
        end
    end

    function automatic logic [31:0] read_port(input logic [4:0] addr);
        if (addr == 5'd0)
            return '0;
        else if (wb_en && dst == addr)
            return src_data;
        else
            return regs[addr];
    endfunction

    assign bus.D_rs_data = read_port(bus.D_rs_addr);
    assign bus.D_rt_data = read_port(bus.D_rt_addr);
endmodule
